muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one operation in flight, fixed latency, write-back triple drives the register-file write port.
module muldiv_unit #(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    input  logic [5:0]   rd,
    output logic         busy,
    output logic         done,
    output logic         regw,
    output logic [5:0]   waddr,
    output logic [n-1:0] wdata,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(n);

    // Handshake: start is accepted only on an edge where busy=0; busy then stays high
    // through the done cycle, so a start held during done is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            regw_q, regw_d;
    logic [5:0]      waddr_q, waddr_d;
    logic [n-1:0]    wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [n-1:0]    opa_q, opa_d;
    logic [n-1:0]    opb_q, opb_d;
    logic [5:0]      rd_q, rd_d;
    logic [2*n-1:0]  acc_q, acc_d;

    function automatic logic signed_a(input logic [2:0] f);
        return f[2] ? ~f[0] : (f[1:0] != 2'b11);
    endfunction

    function automatic logic signed_b(input logic [2:0] f);
        return f[2] ? ~f[0] : ~f[1];
    endfunction

    function automatic logic [n-1:0] mag(input logic [n-1:0] v, input logic sgn);
        return (sgn && v[n-1]) ? (~v + 1'b1) : v;
    endfunction

    logic           sa, sb, a_neg, b_neg;
    logic [n-1:0]   a_mag, b_mag;
    logic [n:0]     mul_sum;
    logic [2*n-1:0] mul_next;
    logic [n:0]     rem_sh;
    logic [n+1:0]   diff;
    logic           fits;
    logic [2*n-1:0] div_next;
    logic [2*n-1:0] prod;
    logic [n-1:0]   quo, rem, quo_s, rem_s;
    logic           div_zero, div_ovf;
    logic [n-1:0]   mul_res, div_res;

    always_comb begin
        sa    = signed_a(funct3_q);
        sb    = signed_b(funct3_q);
        a_neg = sa & opa_q[n-1];
        b_neg = sb & opb_q[n-1];
        a_mag = mag(opa_q, sa);
        b_mag = mag(opb_q, sb);

        // acc = {partial product high, multiplier bits still to consume}
        mul_sum  = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, a_mag} : '0);
        mul_next = {mul_sum, acc_q[n-1:1]};

        // acc = {partial remainder, dividend bits still to consume / quotient bits}
        rem_sh   = {acc_q[2*n-1:n], acc_q[n-1]};
        diff     = {1'b0, rem_sh} - {2'b00, b_mag};
        fits     = ~diff[n+1];
        div_next = {(fits ? diff[n-1:0] : rem_sh[n-1:0]), acc_q[n-2:0], fits};

        prod    = (a_neg ^ b_neg) ? (~acc_q + 1'b1) : acc_q;
        mul_res = (funct3_q[1:0] == 2'b00) ? prod[n-1:0] : prod[2*n-1:n];

        quo      = acc_q[n-1:0];
        rem      = acc_q[2*n-1:n];
        quo_s    = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
        rem_s    = a_neg ? (~rem + 1'b1) : rem;
        div_zero = (opb_q == '0);
        div_ovf  = sa && (opa_q == {1'b1, {(n-1){1'b0}}}) && (opb_q == '1);
        if (div_zero) begin
            quo_s = '1;
            rem_s = opa_q;
        end else if (div_ovf) begin
            quo_s = opa_q;
            rem_s = '0;
        end
        div_res = funct3_q[1] ? rem_s : quo_s;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        regw_d   = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        acc_d    = acc_q;

        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    // done cycle: drop busy, ignore any start seen on this edge
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d   = 1'b1;
                    funct3_d = funct3;
                    opa_d    = opA;
                    opb_d    = opB;
                    rd_d     = rd;
                    cnt_d    = CW'(n - 1);
                    if (funct3[2]) begin
                        state_d = DIV;
                        acc_d   = {{n{1'b0}}, mag(opA, signed_a(funct3))};
                    end else begin
                        state_d = MUL;
                        acc_d   = {{n{1'b0}}, mag(opB, signed_b(funct3))};
                    end
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                regw_d  = (rd_q != 6'd0);
                waddr_d = rd_q;
                wdata_d = funct3_q[2] ? div_res : mul_res;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            regw_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            regw_q   <= regw_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign regw      = regw_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, exact latency, control and reset cases.
module tb_muldiv_unit;
  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic [5:0]  rd = 6'd0;
  logic        busy, done, regw;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_unit #(.n(32)) dut (
    .clock(clock), .nreset(nreset), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .rd(rd),
    .busy(busy), .done(done), .regw(regw), .waddr(waddr), .wdata(wdata),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one start pulse (sampled on the next edge), then scramble the inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] r);
    funct3 = f; opA = a; opB = b; rd = r; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    opA = $urandom; opB = $urandom; rd = 6'($urandom_range(0, 63)); funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_data,
                           input logic [5:0] exp_rd);
    int k;
    logic busy_ok;
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clock); #1;
      k++;
      if (!busy) busy_ok = 1'b0;
    end while (!done && k < 60);
    check($sformatf("%s latency", tag), k, exp_lat);
    check($sformatf("%s wdata", tag), wdata, exp_data);
    check($sformatf("%s waddr", tag), {26'd0, waddr}, {26'd0, exp_rd});
    check($sformatf("%s regw", tag), {31'd0, regw}, {31'd0, exp_rd != 6'd0});
    check($sformatf("%s busy held", tag), {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic after_done(input string tag, input logic [31:0] exp_data);
    @(posedge clock); #1;
    check($sformatf("%s done drop", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s regw drop", tag), {31'd0, regw}, 32'd0);
    check($sformatf("%s busy drop", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s wdata hold", tag), wdata, exp_data);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] r, input logic [31:0] e);
    issue(f, a, b, r);
    wait_done(tag, 33, e, r);
    after_done(tag, e);
  endtask

  initial begin
    // reset state
    nreset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst regw", {31'd0, regw}, 32'd0);
    check("rst waddr", {26'd0, waddr}, 32'd0);
    check("rst wdata", wdata, 32'd0);
    check("rst state", {30'd0, dbg_state}, 32'd0);
    nreset = 1'b1;

    // multiply family
    run_op("mul 7x-3",        F_MUL,    32'd7,        32'hFFFF_FFFD, 6'd5,  32'hFFFF_FFEB);
    run_op("mulh min*min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 6'd6, 32'h4000_0000);
    run_op("mulhu max*max",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'hFFFF_FFFE);
    run_op("mulhsu -1x2",     F_MULHSU, 32'hFFFF_FFFF, 32'd2,        6'd8,  32'hFFFF_FFFF);

    // divide family
    run_op("div -7/2",        F_DIV,  32'hFFFF_FFF9, 32'd2,         6'd9,  32'hFFFF_FFFD);
    run_op("rem -7/2",        F_REM,  32'hFFFF_FFF9, 32'd2,         6'd10, 32'hFFFF_FFFF);
    run_op("div 7/-2",        F_DIV,  32'd7,         32'hFFFF_FFFE, 6'd11, 32'hFFFF_FFFD);
    run_op("rem 7/-2",        F_REM,  32'd7,         32'hFFFF_FFFE, 6'd12, 32'd1);
    run_op("divu 100/7",      F_DIVU, 32'd100,       32'd7,         6'd13, 32'd14);
    run_op("remu 100/7",      F_REMU, 32'd100,       32'd7,         6'd14, 32'd2);
    run_op("divu 7/0",        F_DIVU, 32'd7,         32'd0,         6'd15, 32'hFFFF_FFFF);
    run_op("remu 7/0",        F_REMU, 32'd7,         32'd0,         6'd16, 32'd7);
    run_op("div 5/0",         F_DIV,  32'd5,         32'd0,         6'd17, 32'hFFFF_FFFF);
    run_op("div ovf",         F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 32'h8000_0000);
    run_op("rem ovf",         F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'd19, 32'd0);

    // start re-pulsed at E5 with new operands is ignored
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 6'd20);
    repeat (4) @(posedge clock);
    #1;
    funct3 = F_DIVU; opA = 32'd100; opB = 32'd7; rd = 6'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("repulse", 28, 32'hFFFF_FFEB, 6'd20);
    after_done("repulse", 32'hFFFF_FFEB);

    // x0 destination: done pulses, no write enable, data still updated
    run_op("rd0 3x5", F_MUL, 32'd3, 32'd5, 6'd0, 32'd15);

    // back-to-back: start held from the done cycle is taken one edge later
    issue(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4);
    wait_done("b2b first", 33, 32'hFFFF_FFFE, 6'd4);
    funct3 = F_MUL; opA = 32'd6; opB = 32'd7; rd = 6'd21; start = 1'b1;
    @(posedge clock); #1;
    check("b2b ignored busy", {31'd0, busy}, 32'd0);
    check("b2b ignored state", {30'd0, dbg_state}, 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("b2b second", 33, 32'd42, 6'd21);
    after_done("b2b second", 32'd42);

    // reset in the middle of a DIVU
    issue(F_DIVU, 32'd100, 32'd7, 6'd22);
    repeat (9) @(posedge clock);
    #1;
    nreset = 1'b0;
    @(posedge clock); #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst regw", {31'd0, regw}, 32'd0);
    check("midrst wdata", wdata, 32'd0);
    check("midrst waddr", {26'd0, waddr}, 32'd0);
    check("midrst state", {30'd0, dbg_state}, 32'd0);
    nreset = 1'b1;
    run_op("post-rst 3x4", F_MUL, 32'd3, 32'd4, 6'd23, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
